uart_cfg: RTL and testbench

UART_CFG -- requirements
Module: uart_cfg

---
 rtl/uart_cfg_pkg.sv | 23 ++
 rtl/uart_fifo.sv | 57 +++++
 rtl/uart_cfg.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_cfg.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cfg_pkg.sv
// rtl/uart_cfg_pkg.sv - shared state, parity encodings and oversampling constant for uart_cfg
package uart_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam int OVS = 16;

   // Mode 11 is deliberately folded into "no parity".
   function automatic logic par_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - first-word-fall-through FIFO with wrap-bit full/empty detection
module uart_fifo #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr,
   input  logic [DW-1:0] w_data,
   input  logic          rd,
   output logic [DW-1:0] r_data,
   output logic          full,
   output logic          empty
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic          do_wr, do_rd;

   always_comb begin
      empty  = (wptr_q == rptr_q);
      full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      // A read frees the slot this cycle, so a write into a full FIFO may proceed.
      do_wr  = wr && (!full || rd);
      do_rd  = rd && !empty;
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_wr) begin
         mem_d[wptr_q[AW-1:0]] = w_data;
         wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_rd) begin
         rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   assign r_data = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/uart_cfg.sv
// rtl/uart_cfg.sv - UART with runtime baud/parity/stop configuration and RX/TX FIFOs
module uart_cfg
   import uart_cfg_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int FIFO_AW = 3,
   parameter int DVSR_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DVSR_W-1:0] dvsr,
   input  logic [1:0]        par_mode,
   input  logic              stop2,
   input  logic [DBIT-1:0]   w_data,
   input  logic              wr_uart,
   output logic              tx_full,
   output logic              tx,
   input  logic              rx,
   input  logic              rd_uart,
   output logic [DBIT-1:0]   r_data,
   output logic              rx_empty,
   output logic              parity_err,
   output logic              frame_err,
   output logic              rx_overrun,
   input  logic              clr_err
);

   logic [DVSR_W-1:0] cnt_q, cnt_d;
   logic              tick;

   uart_state_e       rx_state_q, rx_state_d, tx_state_q, tx_state_d;
   logic [3:0]        rx_s_q, rx_s_d, tx_s_q, tx_s_d;
   logic [2:0]        rx_n_q, rx_n_d, tx_n_q, tx_n_d;
   logic [DBIT-1:0]   rx_b_q, rx_b_d, tx_b_q, tx_b_d;
   logic [1:0]        rx_par_q, rx_par_d;
   logic              rx_stop2_q, rx_stop2_d, tx_stop2_q, tx_stop2_d;
   logic              tx_pen_q, tx_pen_d, tx_pbit_q, tx_pbit_d;
   logic              parity_err_q, parity_err_d, frame_err_q, frame_err_d;
   logic              rx_overrun_q, rx_overrun_d;

   logic              rx_done, rx_perr_evt, rx_ferr_evt, rx_exp_par, rx_full;
   logic              tx_pop, tx_empty;
   logic [DBIT-1:0]   tx_fifo_data;

   uart_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_tx_fifo (
      .clk(clk), .reset_n(reset_n), .wr(wr_uart), .w_data(w_data),
      .rd(tx_pop), .r_data(tx_fifo_data), .full(tx_full), .empty(tx_empty)
   );

   uart_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_rx_fifo (
      .clk(clk), .reset_n(reset_n), .wr(rx_done), .w_data(rx_b_q),
      .rd(rd_uart), .r_data(r_data), .full(rx_full), .empty(rx_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q        <= '0;
         rx_state_q   <= ST_IDLE;
         rx_s_q       <= '0;
         rx_n_q       <= '0;
         rx_b_q       <= '0;
         rx_par_q     <= PAR_NONE;
         rx_stop2_q   <= 1'b0;
         tx_state_q   <= ST_IDLE;
         tx_s_q       <= '0;
         tx_n_q       <= '0;
         tx_b_q       <= '0;
         tx_pen_q     <= 1'b0;
         tx_pbit_q    <= 1'b0;
         tx_stop2_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         rx_state_q   <= rx_state_d;
         rx_s_q       <= rx_s_d;
         rx_n_q       <= rx_n_d;
         rx_b_q       <= rx_b_d;
         rx_par_q     <= rx_par_d;
         rx_stop2_q   <= rx_stop2_d;
         tx_state_q   <= tx_state_d;
         tx_s_q       <= tx_s_d;
         tx_n_q       <= tx_n_d;
         tx_b_q       <= tx_b_d;
         tx_pen_q     <= tx_pen_d;
         tx_pbit_q    <= tx_pbit_d;
         tx_stop2_q   <= tx_stop2_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         rx_overrun_q <= rx_overrun_d;
      end
   end

   always_comb begin
      tick  = (cnt_q == dvsr);
      cnt_d = tick ? '0 : cnt_q + DVSR_W'(1);
      rx_exp_par = (rx_par_q == PAR_ODD) ? ~^rx_b_q : ^rx_b_q;

      rx_state_d  = rx_state_q;
      rx_s_d      = rx_s_q;
      rx_n_d      = rx_n_q;
      rx_b_d      = rx_b_q;
      rx_par_d    = rx_par_q;
      rx_stop2_d  = rx_stop2_q;
      rx_done     = 1'b0;
      rx_perr_evt = 1'b0;
      rx_ferr_evt = 1'b0;
      unique case (rx_state_q)
         ST_IDLE: if (!rx) begin
            rx_state_d = ST_START;
            rx_s_d     = '0;
            rx_par_d   = par_mode;
            rx_stop2_d = stop2;
         end
         // Re-check at mid start bit so a short low glitch does not start a frame.
         ST_START: if (tick) begin
            if (rx_s_q == 4'(OVS/2 - 1)) begin
               rx_s_d     = '0;
               rx_n_d     = '0;
               rx_state_d = rx ? ST_IDLE : ST_DATA;
            end else rx_s_d = rx_s_q + 4'd1;
         end
         ST_DATA: if (tick) begin
            if (rx_s_q == 4'(OVS - 1)) begin
               rx_s_d = '0;
               rx_b_d = {rx, rx_b_q[DBIT-1:1]};
               if (rx_n_q == 3'(DBIT - 1)) begin
                  rx_n_d     = '0;
                  rx_state_d = par_enabled(rx_par_q) ? ST_PARITY : ST_STOP;
               end else rx_n_d = rx_n_q + 3'd1;
            end else rx_s_d = rx_s_q + 4'd1;
         end
         ST_PARITY: if (tick) begin
            if (rx_s_q == 4'(OVS - 1)) begin
               rx_s_d      = '0;
               rx_perr_evt = (rx != rx_exp_par);
               rx_state_d  = ST_STOP;
            end else rx_s_d = rx_s_q + 4'd1;
         end
         ST_STOP: if (tick) begin
            if (rx_s_q == 4'(OVS - 1)) begin
               rx_s_d      = '0;
               rx_ferr_evt = !rx;
               if (rx_n_q == 3'(rx_stop2_q)) begin
                  rx_done    = 1'b1;
                  rx_state_d = ST_IDLE;
               end else rx_n_d = rx_n_q + 3'd1;
            end else rx_s_d = rx_s_q + 4'd1;
         end
         default: rx_state_d = ST_IDLE;
      endcase

      tx_state_d = tx_state_q;
      tx_s_d     = tx_s_q;
      tx_n_d     = tx_n_q;
      tx_b_d     = tx_b_q;
      tx_pen_d   = tx_pen_q;
      tx_pbit_d  = tx_pbit_q;
      tx_stop2_d = tx_stop2_q;
      tx_pop     = 1'b0;
      unique case (tx_state_q)
         ST_IDLE: tx_pop = !tx_empty;
         ST_START: if (tick) begin
            if (tx_s_q == 4'(OVS - 1)) begin
               tx_s_d     = '0;
               tx_n_d     = '0;
               tx_state_d = ST_DATA;
            end else tx_s_d = tx_s_q + 4'd1;
         end
         ST_DATA: if (tick) begin
            if (tx_s_q == 4'(OVS - 1)) begin
               tx_s_d = '0;
               tx_b_d = tx_b_q >> 1;
               if (tx_n_q == 3'(DBIT - 1)) begin
                  tx_n_d     = '0;
                  tx_state_d = tx_pen_q ? ST_PARITY : ST_STOP;
               end else tx_n_d = tx_n_q + 3'd1;
            end else tx_s_d = tx_s_q + 4'd1;
         end
         ST_PARITY: if (tick) begin
            if (tx_s_q == 4'(OVS - 1)) begin
               tx_s_d     = '0;
               tx_state_d = ST_STOP;
            end else tx_s_d = tx_s_q + 4'd1;
         end
         // Chaining straight into the next start bit avoids an idle gap between frames.
         ST_STOP: if (tick) begin
            if (tx_s_q == 4'(OVS - 1)) begin
               tx_s_d = '0;
               if (tx_n_q == 3'(tx_stop2_q)) begin
                  tx_state_d = ST_IDLE;
                  tx_pop     = !tx_empty;
               end else tx_n_d = tx_n_q + 3'd1;
            end else tx_s_d = tx_s_q + 4'd1;
         end
         default: tx_state_d = ST_IDLE;
      endcase
      if (tx_pop) begin
         tx_state_d = ST_START;
         tx_s_d     = '0;
         tx_b_d     = tx_fifo_data;
         tx_pen_d   = par_enabled(par_mode);
         tx_pbit_d  = (par_mode == PAR_ODD) ? ~^tx_fifo_data : ^tx_fifo_data;
         tx_stop2_d = stop2;
      end

      // A new error event outranks a simultaneous clear.
      parity_err_d = (clr_err ? 1'b0 : parity_err_q) | rx_perr_evt;
      frame_err_d  = (clr_err ? 1'b0 : frame_err_q) | rx_ferr_evt;
      rx_overrun_d = (clr_err ? 1'b0 : rx_overrun_q) | (rx_done && rx_full && !rd_uart);
   end

   always_comb begin
      unique case (tx_state_q)
         ST_START:  tx = 1'b0;
         ST_DATA:   tx = tx_b_q[0];
         ST_PARITY: tx = tx_pbit_q;
         default:   tx = 1'b1;
      endcase
      parity_err = parity_err_q;
      frame_err  = frame_err_q;
      rx_overrun = rx_overrun_q;
   end

endmodule

// File: tb/tb_uart_cfg.sv
// tb/tb_uart_cfg.sv - directed self-checking bench for uart_cfg
module tb_uart_cfg;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] dvsr;
   logic [1:0]  par_mode;
   logic        stop2;
   logic [7:0]  w_data;
   logic        wr_uart;
   logic        tx_full;
   logic        tx;
   logic        rx;
   logic        rd_uart;
   logic [7:0]  r_data;
   logic        rx_empty;
   logic        parity_err, frame_err, rx_overrun;
   logic        clr_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mon_q[$];
   int         mon_stop_bad = 0;

   always #5 clk = ~clk;

   uart_cfg #(.DBIT(8), .FIFO_AW(3), .DVSR_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .dvsr(dvsr), .par_mode(par_mode), .stop2(stop2),
      .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full), .tx(tx), .rx(rx),
      .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty), .parity_err(parity_err),
      .frame_err(frame_err), .rx_overrun(rx_overrun), .clr_err(clr_err)
   );

   // Decodes 8N1 frames at 16 clocks per bit from tx, sampling mid-bit.
   initial begin : tx_monitor
      logic [7:0] d;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && tx === 1'b0) begin
            repeat (8) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (16) @(negedge clk);
               d[i] = tx;
            end
            repeat (16) @(negedge clk);
            if (tx !== 1'b1) mon_stop_bad++;
            mon_q.push_back(d);
         end
      end
   end

   task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input bit bad_par,
                             input logic stop_val, input int nstop);
      logic bits[$];
      logic p;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pm == 2'b01 || pm == 2'b10) begin
         p = (pm == 2'b10) ? ~^d : ^d;
         if (bad_par) p = ~p;
         bits.push_back(p);
      end
      bits.push_back(stop_val);
      if (nstop == 2) bits.push_back(1'b1);
      foreach (bits[k]) begin
         repeat (16) begin
            @(posedge clk); #1 rx = bits[k];
         end
      end
      repeat (32) begin
         @(posedge clk); #1 rx = 1'b1;
      end
   endtask

   task automatic pop_rx();
      @(posedge clk); #1 rd_uart = 1'b1;
      @(posedge clk); #1 rd_uart = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 clr_err = 1'b1;
      @(posedge clk); #1 clr_err = 1'b0;
   endtask

   task automatic write_tx(input logic [7:0] d);
      @(posedge clk); #1 wr_uart = 1'b1; w_data = d;
      @(posedge clk); #1 wr_uart = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; dvsr = 16'd0; par_mode = 2'b00; stop2 = 1'b0; w_data = 8'h00;
      wr_uart = 1'b0; rx = 1'b1; rd_uart = 1'b0; clr_err = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
      n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL reset_tx_full: got %b want 0", tx_full); end
      n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_rx_empty: got %b want 1", rx_empty); end
      n_checks++; if (r_data !== 8'h00) begin n_fail++; $display("FAIL reset_r_data: got %h want 00", r_data); end
      n_checks++; if ({parity_err, frame_err, rx_overrun} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 000", {parity_err, frame_err, rx_overrun});
      end
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_idle_tx: got %b want 1", tx); end
   endtask

   task automatic test_rx_basic();
      par_mode = 2'b00; stop2 = 1'b0;
      send_frame(8'h9F, 2'b00, 1'b0, 1'b1, 1);
      @(negedge clk);
      n_checks++; if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL rx_basic_empty: got %b want 0", rx_empty); end
      n_checks++; if (r_data !== 8'h9F) begin n_fail++; $display("FAIL rx_basic_data: got %h want 9f", r_data); end
      n_checks++; if ({parity_err, frame_err, rx_overrun} !== 3'b000) begin
         n_fail++; $display("FAIL rx_basic_flags: got %b want 000", {parity_err, frame_err, rx_overrun});
      end
      pop_rx();
      n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rx_basic_pop: got %b want 1", rx_empty); end
   endtask

   task automatic test_tx_even();
      logic [10:0] exp_bits;
      bit found;
      exp_bits = {1'b1, 1'b0, 8'h55, 1'b0};
      par_mode = 2'b01; stop2 = 1'b0;
      write_tx(8'h55);
      found = 1'b0;
      for (int c = 0; c < 64 && !found; c++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL tx_even_start: got no start bit want one"); end
      if (found) begin
         for (int c = 0; c < 176; c++) begin
            n_checks++;
            if (tx !== exp_bits[c/16]) begin
               n_fail++; $display("FAIL tx_even_bit%0d_cyc%0d: got %b want %b", c/16, c%16, tx, exp_bits[c/16]);
            end
            @(negedge clk);
         end
         for (int c = 0; c < 32; c++) begin
            n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_even_idle: got %b want 1", tx); end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_tx_cfg_latch();
      logic [13:0] exp_bits;
      bit found;
      exp_bits = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0};
      par_mode = 2'b10; stop2 = 1'b1;
      write_tx(8'h03);
      found = 1'b0;
      for (int c = 0; c < 64 && !found; c++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL cfg_latch_start: got no start bit want one"); end
      if (found) begin
         for (int c = 0; c < 224; c++) begin
            if (c == 0) begin par_mode = 2'b00; stop2 = 1'b0; wr_uart = 1'b1; w_data = 8'hC4; end
            if (c == 1) wr_uart = 1'b0;
            n_checks++;
            if (tx !== exp_bits[c/16]) begin
               n_fail++; $display("FAIL cfg_latch_bit%0d_cyc%0d: got %b want %b", c/16, c%16, tx, exp_bits[c/16]);
            end
            @(negedge clk);
         end
      end
      repeat (200) @(negedge clk);
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL cfg_latch_idle: got %b want 1", tx); end
   endtask

   task automatic test_tx_nine();
      par_mode = 2'b00; stop2 = 1'b0;
      repeat (100) @(posedge clk);
      mon_q.delete();
      mon_stop_bad = 0;
      @(posedge clk); #1 wr_uart = 1'b1; w_data = 8'd1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (i == 8) begin
            n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL nine_full_after8: got %b want 0", tx_full); end
         end
         if (i >= 9) begin
            n_checks++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL nine_full_after%0d: got %b want 1", i, tx_full); end
         end
         if (i < 9) w_data = 8'(i + 1);
         else if (i == 9) w_data = 8'hAA;
         else wr_uart = 1'b0;
      end
      repeat (1800) @(posedge clk);
      @(negedge clk);
      n_checks++; if (mon_q.size() != 9) begin n_fail++; $display("FAIL nine_frames: got %0d want 9", mon_q.size()); end
      for (int i = 0; i < 9 && i < mon_q.size(); i++) begin
         n_checks++;
         if (mon_q[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL nine_data%0d: got %h want %h", i, mon_q[i], 8'(i + 1)); end
      end
      n_checks++; if (mon_stop_bad != 0) begin n_fail++; $display("FAIL nine_stop: got %0d bad want 0", mon_stop_bad); end
      n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL nine_drained: got %b want 0", tx_full); end
   endtask

   task automatic test_frame_err();
      par_mode = 2'b00; stop2 = 1'b0;
      send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1);
      @(negedge clk);
      n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b want 1", frame_err); end
      n_checks++; if (r_data !== 8'hA5) begin n_fail++; $display("FAIL ferr_data: got %h want a5", r_data); end
      n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL ferr_perr: got %b want 0", parity_err); end
      send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 1);
      @(negedge clk);
      n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky: got %b want 1", frame_err); end
      n_checks++; if (r_data !== 8'hA5) begin n_fail++; $display("FAIL ferr_head: got %h want a5", r_data); end
      pop_rx();
      n_checks++; if (r_data !== 8'h5A) begin n_fail++; $display("FAIL ferr_second: got %h want 5a", r_data); end
      pop_rx();
      n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL ferr_empty: got %b want 1", rx_empty); end
      pulse_clr();
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clr: got %b want 0", frame_err); end
   endtask

   task automatic test_parity_overrun();
      par_mode = 2'b10; stop2 = 1'b0;
      send_frame(8'h03, 2'b10, 1'b1, 1'b1, 1);
      @(negedge clk);
      n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b want 1", parity_err); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL perr_ferr: got %b want 0", frame_err); end
      n_checks++; if (r_data !== 8'h03) begin n_fail++; $display("FAIL perr_data: got %h want 03", r_data); end
      pop_rx();
      pulse_clr();
      n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL perr_clr: got %b want 0", parity_err); end
      for (int i = 0; i < 9; i++) begin
         send_frame(8'h10 + 8'(i), 2'b10, 1'b0, 1'b1, 1);
         if (i == 7) begin
            n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b want 0", rx_overrun); end
         end
      end
      @(negedge clk);
      n_checks++; if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", rx_overrun); end
      n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL ovr_perr: got %b want 0", parity_err); end
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL ovr_empty%0d: got %b want 0", i, rx_empty); end
         n_checks++;
         if (r_data !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL ovr_data%0d: got %h want %h", i, r_data, 8'h10 + 8'(i)); end
         pop_rx();
      end
      n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL ovr_lost: got %b want 1", rx_empty); end
      pulse_clr();
      n_checks++; if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b want 0", rx_overrun); end
   endtask

   task automatic test_reset_mid();
      int cnt;
      bit found;
      par_mode = 2'b00; stop2 = 1'b0; dvsr = 16'd0;
      send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1);
      @(negedge clk);
      n_checks++; if (r_data !== 8'h3C) begin n_fail++; $display("FAIL rmid_rx_pre: got %h want 3c", r_data); end
      dvsr = 16'd3;
      @(posedge clk); #1 wr_uart = 1'b1; w_data = 8'h01;
      @(posedge clk); #1 w_data = 8'h02;
      @(posedge clk); #1 w_data = 8'h03;
      @(posedge clk); #1 wr_uart = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL rmid_start: got no start bit want one"); end
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (tx === 1'b1) found = 1'b1;
      end
      n_checks++; if (!found) begin n_fail++; $display("FAIL rmid_bit0: got no data bit want one"); end
      cnt = 0;
      while (tx === 1'b1 && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      n_checks++; if (cnt != 64) begin n_fail++; $display("FAIL rmid_bitlen: got %0d want 64", cnt); end
      repeat (10) @(negedge clk);
      n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rmid_bit1: got %b want 0", tx); end
      #2 reset_n = 1'b0;
      #1;
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rmid_tx: got %b want 1", tx); end
      n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rmid_rx_empty: got %b want 1", rx_empty); end
      n_checks++; if (r_data !== 8'h00) begin n_fail++; $display("FAIL rmid_r_data: got %h want 00", r_data); end
      n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL rmid_tx_full: got %b want 0", tx_full); end
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (tx !== 1'b1) cnt++;
      end
      n_checks++; if (cnt != 0) begin n_fail++; $display("FAIL rmid_no_resume: got %0d low cycles want 0", cnt); end
      n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rmid_rx_after: got %b want 1", rx_empty); end
   endtask

   initial begin
      test_reset();
      test_rx_basic();
      test_tx_even();
      test_tx_cfg_latch();
      test_tx_nine();
      test_frame_err();
      test_parity_overrun();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
